// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame position/velocity controller for one
// keyboard-driven sprite, with screen clamping and a timed dash/cooldown.
// The keycode sampled at a frame edge moves the sprite on that same edge.
//
// Optional build macro: SPRITE_MOTION_ACCEL_EN
//   defined   : walk velocity ramps toward the decoded target by ACCEL/frame
//   undefined : walk velocity equals the decoded target immediately
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no applied velocity, waiting for a movement key
// WALK     | moving at the decoded (or ramped) walk velocity
// DASH     | latched velocity x DASH_MUL for DASH_FRAMES moves, keys ignored
// COOLDOWN | walking allowed, dash_req ignored until the counter expires

module sprite_motion_ctrl #(
    parameter int W               = 10,
    parameter int X_CENTER        = 320,
    parameter int Y_CENTER        = 450,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 639,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 479,
    parameter int SIZE            = 4,
    parameter int WALK_STEP       = 4,
    parameter int DIAG_STEP       = 3,
    parameter int DASH_MUL        = 4,
    parameter int DASH_FRAMES     = 8,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int ACCEL           = 1
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic [7:0]   keycode,
    input  logic         dash_req,
    output logic [W-1:0] PosX,
    output logic [W-1:0] PosY,
    output logic [W-1:0] Size,
    output logic [1:0]   Dir,
    output logic [1:0]   State,
    output logic         Moving,
    output logic         BlockX,
    output logic         BlockY
);

    // Velocities and candidate positions are signed, two bits wider than a
    // position so that overshoot past either screen edge is representable.
    localparam int VW = W + 2;
    localparam int CW = W;

    localparam logic signed [VW-1:0] SZ  = VW'(SIZE);
    localparam logic signed [VW-1:0] XLO = VW'(X_MIN);
    localparam logic signed [VW-1:0] XHI = VW'(X_MAX);
    localparam logic signed [VW-1:0] YLO = VW'(Y_MIN);
    localparam logic signed [VW-1:0] YHI = VW'(Y_MAX);
    localparam logic signed [VW-1:0] DS  = VW'(DIAG_STEP);
    localparam logic signed [VW-1:0] WS  = VW'(WALK_STEP);
    localparam logic signed [VW-1:0] MUL = VW'(DASH_MUL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_DASH = 2'd2,
        S_COOL = 2'd3
    } state_t;

    state_t state;

    logic signed [VW-1:0] tgt_vx, tgt_vy;
    logic signed [VW-1:0] walk_vx, walk_vy;
    logic signed [VW-1:0] dash_vx, dash_vy;
    logic signed [VW-1:0] app_vx, app_vy;
    logic signed [VW-1:0] next_x, next_y;
    logic signed [VW-1:0] clamp_x, clamp_y;
    logic                 blk_x, blk_y;
    logic [CW-1:0]        dash_cnt, cool_cnt;
    logic                 tgt_nz, walk_active, dash_start, leave_dash;

    // Keycode decode into the target walk velocity (y positive down).
    always_comb begin
        tgt_vx = '0;
        tgt_vy = '0;
        case (keycode)
            8'h01: begin tgt_vx =  DS; tgt_vy = -DS; end
            8'h02: begin tgt_vx = -DS; tgt_vy = -DS; end
            8'h03: begin tgt_vx =  DS; tgt_vy =  DS; end
            8'h04: begin tgt_vx = -DS; tgt_vy =  DS; end
            8'h05: begin tgt_vx = -WS; tgt_vy = '0;  end
            8'h07: begin tgt_vx =  WS; tgt_vy = '0;  end
            8'h16: begin tgt_vx = '0;  tgt_vy =  WS; end
            8'h1A: begin tgt_vx = '0;  tgt_vy = -WS; end
            default: begin tgt_vx = '0; tgt_vy = '0; end
        endcase
    end

`ifdef SPRITE_MOTION_ACCEL_EN
    localparam logic signed [VW-1:0] ACC = VW'(ACCEL);

    logic signed [VW-1:0] vel_x, vel_y;

    function automatic logic signed [VW-1:0] ramp(input logic signed [VW-1:0] cur,
                                                  input logic signed [VW-1:0] tgt);
        if (tgt > cur + ACC)
            return cur + ACC;
        else if (tgt < cur - ACC)
            return cur - ACC;
        else
            return tgt;
    endfunction

    assign walk_vx = ramp(vel_x, tgt_vx);
    assign walk_vy = ramp(vel_y, tgt_vy);

    // Walk velocity memory; during a dash it follows the target so the ramp
    // picks up from the walk target when the dash ends.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            vel_x <= '0;
            vel_y <= '0;
        end else if (state == S_DASH || dash_start) begin
            vel_x <= tgt_vx;
            vel_y <= tgt_vy;
        end else begin
            vel_x <= walk_vx;
            vel_y <= walk_vy;
        end
    end
`else
    assign walk_vx = tgt_vx;
    assign walk_vy = tgt_vy;
`endif

    assign tgt_nz      = (tgt_vx != '0) || (tgt_vy != '0);
    assign walk_active = tgt_nz || (walk_vx != '0) || (walk_vy != '0);
    assign dash_start  = (state == S_IDLE || state == S_WALK) && dash_req && tgt_nz;
    assign leave_dash  = (state == S_DASH && dash_cnt <= CW'(1)) ||
                         (dash_start && DASH_FRAMES <= 1);

    // Applied velocity: latched dash, fresh dash on the entry frame, else walk.
    always_comb begin
        app_vx = walk_vx;
        app_vy = walk_vy;
        if (state == S_DASH) begin
            app_vx = dash_vx;
            app_vy = dash_vy;
        end else if (dash_start) begin
            app_vx = tgt_vx * MUL;
            app_vy = tgt_vy * MUL;
        end
    end

    // Candidate position and independent per-axis clamping.
    always_comb begin
        next_x  = $signed({2'b00, PosX}) + app_vx;
        next_y  = $signed({2'b00, PosY}) + app_vy;
        clamp_x = next_x;
        clamp_y = next_y;
        blk_x   = 1'b0;
        blk_y   = 1'b0;
        if (next_x - SZ < XLO) begin
            clamp_x = XLO + SZ;
            blk_x   = 1'b1;
        end else if (next_x + SZ > XHI) begin
            clamp_x = XHI - SZ;
            blk_x   = 1'b1;
        end
        if (next_y - SZ < YLO) begin
            clamp_y = YLO + SZ;
            blk_y   = 1'b1;
        end else if (next_y + SZ > YHI) begin
            clamp_y = YHI - SZ;
            blk_y   = 1'b1;
        end
    end

    // Main FSM with registered position, facing and status outputs.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            PosX     <= W'(X_CENTER);
            PosY     <= W'(Y_CENTER);
            Dir      <= 2'd0;
            Moving   <= 1'b0;
            BlockX   <= 1'b0;
            BlockY   <= 1'b0;
            dash_vx  <= '0;
            dash_vy  <= '0;
            dash_cnt <= '0;
            cool_cnt <= '0;
        end else begin
            PosX   <= W'(clamp_x);
            PosY   <= W'(clamp_y);
            BlockX <= blk_x;
            BlockY <= blk_y;
            Moving <= (app_vx != '0) || (app_vy != '0);

            // Horizontal component decides facing on diagonals.
            if (app_vx != '0)
                Dir <= app_vx[VW-1] ? 2'd1 : 2'd0;
            else if (app_vy != '0)
                Dir <= app_vy[VW-1] ? 2'd2 : 2'd3;

            case (state)
                S_IDLE, S_WALK: begin
                    if (dash_start) begin
                        dash_vx  <= tgt_vx * MUL;
                        dash_vy  <= tgt_vy * MUL;
                        dash_cnt <= CW'(DASH_FRAMES - 1);
                        state    <= S_DASH;
                    end else begin
                        state <= walk_active ? S_WALK : S_IDLE;
                    end
                end
                S_DASH: begin
                    if (!leave_dash)
                        dash_cnt <= dash_cnt - CW'(1);
                end
                S_COOL: begin
                    if (cool_cnt == '0)
                        state <= walk_active ? S_WALK : S_IDLE;
                    else
                        cool_cnt <= cool_cnt - CW'(1);
                end
                default: state <= S_IDLE;
            endcase

            // Dash end overrides the case above; a zero cooldown skips COOLDOWN.
            if (leave_dash) begin
                dash_cnt <= '0;
                if (COOLDOWN_FRAMES > 0) begin
                    state    <= S_COOL;
                    cool_cnt <= CW'(COOLDOWN_FRAMES - 1);
                end else begin
                    state <= walk_active ? S_WALK : S_IDLE;
                end
            end
        end
    end

    assign State = state;
    assign Size  = W'(SIZE);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with default parameters.
module tb_sprite_motion_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [7:0] keycode   = 8'h00;
    logic       dash_req  = 1'b0;
    logic [9:0] PosX, PosY, Size;
    logic [1:0] Dir, State;
    logic       Moving, BlockX, BlockY;

    int total = 0;
    int bad   = 0;

    sprite_motion_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .dash_req  (dash_req),
        .PosX      (PosX),
        .PosY      (PosY),
        .Size      (Size),
        .Dir       (Dir),
        .State     (State),
        .Moving    (Moving),
        .BlockX    (BlockX),
        .BlockY    (BlockY)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic       rst;
        logic [7:0] kc;
        logic       dr;
        int         x, y, st, dir, mv, bx, by;
    } vec_t;

    vec_t vecs[22];

    task automatic step(input logic r, input logic [7:0] k, input logic d);
        Reset    = r;
        keycode  = k;
        dash_req = d;
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    task automatic expect_out(input string nm, input int x, input int y, input int st,
                              input int dir, input int mv, input int bx, input int by);
        total++;
        if ($isunknown({PosX, PosY, State, Dir, Moving, BlockX, BlockY}) ||
            PosX != x || PosY != y || State != st || Dir != dir ||
            Moving != mv || BlockX != bx || BlockY != by) begin
            bad++;
            $display("FAIL %s: got x=%0d y=%0d st=%0d dir=%0d mv=%0d bx=%0d by=%0d, want x=%0d y=%0d st=%0d dir=%0d mv=%0d bx=%0d by=%0d",
                     nm, PosX, PosY, State, Dir, Moving, BlockX, BlockY,
                     x, y, st, dir, mv, bx, by);
        end
    endtask

    initial begin
        // rst, kc, dr, x, y, state, dir, moving, bx, by  (one frame edge each)
        vecs[0]  = '{1'b1, 8'h00, 1'b0, 320, 450, 0, 0, 0, 0, 0};
        vecs[1]  = '{1'b1, 8'h00, 1'b0, 320, 450, 0, 0, 0, 0, 0};
        vecs[2]  = '{1'b0, 8'h07, 1'b0, 324, 450, 1, 0, 1, 0, 0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 324, 450, 0, 0, 0, 0, 0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 324, 450, 0, 0, 0, 0, 0};
        vecs[5]  = '{1'b0, 8'h16, 1'b0, 324, 454, 1, 3, 1, 0, 0};
        vecs[6]  = '{1'b0, 8'h16, 1'b0, 324, 458, 1, 3, 1, 0, 0};
        vecs[7]  = '{1'b0, 8'h16, 1'b0, 324, 462, 1, 3, 1, 0, 0};
        vecs[8]  = '{1'b0, 8'h16, 1'b0, 324, 466, 1, 3, 1, 0, 0};
        vecs[9]  = '{1'b0, 8'h16, 1'b0, 324, 470, 1, 3, 1, 0, 0};
        vecs[10] = '{1'b0, 8'h16, 1'b0, 324, 474, 1, 3, 1, 0, 0};
        vecs[11] = '{1'b0, 8'h16, 1'b0, 324, 475, 1, 3, 1, 0, 1};
        vecs[12] = '{1'b0, 8'h16, 1'b0, 324, 475, 1, 3, 1, 0, 1};
        vecs[13] = '{1'b0, 8'h1A, 1'b0, 324, 471, 1, 2, 1, 0, 0};
        vecs[14] = '{1'b0, 8'h01, 1'b0, 327, 468, 1, 0, 1, 0, 0};
        vecs[15] = '{1'b0, 8'h04, 1'b0, 324, 471, 1, 1, 1, 0, 0};
        vecs[16] = '{1'b0, 8'h03, 1'b0, 327, 474, 1, 0, 1, 0, 0};
        vecs[17] = '{1'b0, 8'h03, 1'b0, 330, 475, 1, 0, 1, 0, 1};
        vecs[18] = '{1'b0, 8'h55, 1'b0, 330, 475, 0, 0, 0, 0, 0};
        vecs[19] = '{1'b0, 8'h02, 1'b0, 327, 472, 1, 1, 1, 0, 0};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 327, 472, 0, 1, 0, 0, 0};
        vecs[21] = '{1'b1, 8'h07, 1'b1, 320, 450, 0, 0, 0, 0, 0};

        @(negedge frame_clk);

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].rst, vecs[i].kc, vecs[i].dr);
            expect_out($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].st,
                       vecs[i].dir, vecs[i].mv, vecs[i].bx, vecs[i].by);
        end

        total++;
        if (Size !== 10'd4) begin
            bad++;
            $display("FAIL size: got %0d want 4", Size);
        end

        // Dash left from centre; keys during the dash must be ignored.
        step(1'b1, 8'h00, 1'b0);
        step(0, 8'h05, 1'b1);
        expect_out("dash_entry", 304, 450, 2, 1, 1, 0, 0);
        for (int k = 2; k <= 8; k++) begin
            step(0, 8'h07, 1'b0);
            expect_out($sformatf("dash_move%0d", k), 320 - 16 * k, 450,
                       (k == 8) ? 3 : 2, 1, 1, 0, 0);
        end
        // Cooldown: dash_req ignored, walk speed only, 30 frames.
        for (int j = 1; j <= 30; j++) begin
            step(0, 8'h05, 1'b1);
            expect_out($sformatf("cool%0d", j), 192 - 4 * j, 450,
                       (j == 30) ? 1 : 3, 1, 1, 0, 0);
        end
        step(0, 8'h05, 1'b1);
        expect_out("dash_again", 56, 450, 2, 1, 1, 0, 0);

        // Reset on the third dash frame, then a full fresh dash.
        step(1'b1, 8'h00, 1'b0);
        step(0, 8'h05, 1'b1);
        expect_out("rdash1", 304, 450, 2, 1, 1, 0, 0);
        step(0, 8'h05, 1'b1);
        expect_out("rdash2", 288, 450, 2, 1, 1, 0, 0);
        step(1'b1, 8'h05, 1'b1);
        expect_out("rdash_reset", 320, 450, 0, 0, 0, 0, 0);
        step(0, 8'h05, 1'b1);
        expect_out("rdash_restart", 304, 450, 2, 1, 1, 0, 0);
        for (int k = 2; k <= 8; k++) begin
            step(0, 8'h00, 1'b0);
            expect_out($sformatf("rdash_move%0d", k), 320 - 16 * k, 450,
                       (k == 8) ? 3 : 2, 1, 1, 0, 0);
        end

        // Up-left diagonal from centre: X pins at 4 first, then Y.
        step(1'b1, 8'h00, 1'b0);
        for (int k = 1; k <= 150; k++) begin
            step(0, 8'h02, 1'b0);
            if (k == 1)   expect_out("diag1",   317, 447, 1, 1, 1, 0, 0);
            if (k == 105) expect_out("diag105", 5,   135, 1, 1, 1, 0, 0);
            if (k == 106) expect_out("diag106", 4,   132, 1, 1, 1, 1, 0);
            if (k == 148) expect_out("diag148", 4,   6,   1, 1, 1, 1, 0);
            if (k == 149) expect_out("diag149", 4,   4,   1, 1, 1, 1, 1);
            if (k == 150) expect_out("diag150", 4,   4,   1, 1, 1, 1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
